// File: rtl/stream_fifo.sv
// First-word fall-through stream FIFO with occupancy count and threshold flags.
// Define STREAM_FIFO_STATS_EN to add the max_level / stall_cnt statistics ports.
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef STREAM_FIFO_STATS_EN
  output logic [$clog2(DEPTH+1)-1:0]   max_level,
  output logic [15:0]                  stall_cnt,
`endif
  output logic                         almost_full,
  output logic                         almost_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_push, w_pop;

  // Handshakes depend only on registered occupancy, never on the other side's strobe.
  assign in_ready     = (r_count != FULL_CNT);
  assign out_valid    = (r_count != '0);
  assign out_data     = r_mem[r_rptr];
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push && !flush && !RST) r_mem[r_wptr] <= in_data;
  end

`ifdef STREAM_FIFO_STATS_EN
  logic [CW-1:0] r_max_level;
  logic [15:0]   r_stall_cnt;

  assign max_level = r_max_level;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (RST || flush)                 r_max_level <= '0;
    else if (w_count_nxt > r_max_level) r_max_level <= w_count_nxt;
  end

  // Stall history survives flush; only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST)                                               r_stall_cnt <= '0;
    else if (in_valid && !in_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: negedge scoreboard checks data order, count and flags
// every cycle; the initial block drives directed steps and spot-checks boundary states.
module tb_stream_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, almost_full, almost_empty;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
`ifdef STREAM_FIFO_STATS_EN
  logic [CW-1:0] max_level;
  logic [15:0]   stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb_q[$];

  always #5 CLK = ~CLK;

  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count),
`ifdef STREAM_FIFO_STATS_EN
    .max_level(max_level), .stall_cnt(stall_cnt),
`endif
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

`ifdef STREAM_FIFO_STATS_EN
  logic          s_rst, s_in_valid;
  logic [DW-1:0] s_out_data;
  logic          s_in_ready, s_out_valid, s_af, s_ae;
  logic [2:0]    s_count, s_max;
  logic [15:0]   s_stall;
  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) u_stats (
    .CLK(CLK), .RST(s_rst), .flush(1'b0),
    .in_valid(s_in_valid), .in_data(32'h5), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(1'b0),
    .count(s_count), .max_level(s_max), .stall_cnt(s_stall),
    .almost_full(s_af), .almost_empty(s_ae)
  );
`endif

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Scoreboard: model occupancy is the queue size; transfers predicted from it.
  always @(negedge CLK) begin
    int mc;
    if (RST) sb_q.delete();
    else begin
      mc = sb_q.size();
      check("in_ready", {31'd0, in_ready}, {31'd0, mc != DEPTH});
      check("out_valid", {31'd0, out_valid}, {31'd0, mc != 0});
      check("count", DW'(count), DW'(mc));
      check("almost_full", {31'd0, almost_full}, {31'd0, mc >= DEPTH - 2});
      check("almost_empty", {31'd0, almost_empty}, {31'd0, mc <= 2});
      if (flush) sb_q.delete();
      else begin
        if (out_ready && mc != 0) begin
          check("out_data", out_data, sb_q[0]);
          void'(sb_q.pop_front());
        end
        if (in_valid && mc != DEPTH) sb_q.push_back(in_data);
      end
    end
  end

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef STREAM_FIFO_STATS_EN
    s_rst = 1'b1; s_in_valid = 1'b0;
`endif
    tick(2);
    RST = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_almost_empty", {31'd0, almost_empty}, 32'd1);
    check("rst_almost_full", {31'd0, almost_full}, 32'd0);
    check("rst_count", DW'(count), 32'd0);

    // single word, 1-cycle fall-through latency
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    check("ft_valid", {31'd0, out_valid}, 32'd1);
    check("ft_data", out_data, 32'hA5A5_0001);
    check("ft_count", DW'(count), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // fill to full, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = DW'(i); tick();
    end
    in_valid = 1'b0;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_count", DW'(count), 32'd32);
    check("full_af", {31'd0, almost_full}, 32'd1);
    out_ready = 1'b1; tick(DEPTH); out_ready = 1'b0;
    check("drain_count", DW'(count), 32'd0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // full with simultaneous pop: push refused this cycle, taken next
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = DW'(100 + i); tick();
    end
    in_data = 32'd99; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pop_count", DW'(count), 32'd31);
    check("full_pop_head", out_data, 32'd101);
    tick();
    in_valid = 1'b0;
    check("refill_count", DW'(count), 32'd32);
    out_ready = 1'b1; tick(DEPTH); out_ready = 1'b0;
    check("refill_drain", DW'(count), 32'd0);

    // steady push+pop at occupancy 5, pointers wrap
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(200 + i); tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = DW'(300 + i); tick();
      check("steady_count", DW'(count), 32'd5);
    end
    in_valid = 1'b0; tick(5); out_ready = 1'b0;
    check("steady_drain", DW'(count), 32'd0);

    // flush beats concurrent push and pop
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = DW'(400 + i); tick();
    end
    flush = 1'b1; in_data = 32'd777; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", DW'(count), 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
`ifdef STREAM_FIFO_STATS_EN
    check("flush_max", DW'(max_level), 32'd0);
`endif
    in_valid = 1'b1; in_data = 32'd888; tick(); in_valid = 1'b0;
    check("post_flush_data", out_data, 32'd888);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // reset mid-stream discards contents
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(500 + i); tick();
    end
    in_valid = 1'b0; RST = 1'b1; tick(); RST = 1'b0;
    check("midrst_count", DW'(count), 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);

`ifdef STREAM_FIFO_STATS_EN
    s_rst = 1'b0; s_in_valid = 1'b1;
    tick(4);
    check("stats_fill_count", DW'(s_count), 32'd4);
    tick(3);
    s_in_valid = 1'b0;
    check("stats_max", DW'(s_max), 32'd4);
    check("stats_stall", DW'(s_stall), 32'd3);
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    check("stats_rst_max", DW'(s_max), 32'd0);
    check("stats_rst_stall", DW'(s_stall), 32'd0);
`endif
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each data word.
REQ-002 SHALL have parameter DEPTH, default 32, number of storage entries; legal values are powers of two >= 2.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  in  1  synchronous discard of all stored entries.
REQ-008 SHALL have port in_valid  in  1  producer presents in_data.
REQ-009 SHALL have port in_data  in  DATA_WIDTH  write data.
REQ-010 SHALL have port in_ready  out  1  FIFO can accept a word this cycle.
REQ-011 SHALL have port out_valid  out  1  out_data holds the oldest stored word.
REQ-012 SHALL have port out_data  out  DATA_WIDTH  read data.
REQ-013 SHALL have port out_ready  in  1  consumer accepts out_data.
REQ-014 SHALL have port count  out  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have ports almost_full and almost_empty  out  1  each  threshold flags.
REQ-016 SHALL have ports max_level  out  $clog2(DEPTH+1)  and stall_cnt  out  16; both present only when STREAM_FIFO_STATS_EN is defined.

Function
REQ-017 Push SHALL occur on a rising edge when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer (first-word fall-through, no output register).
REQ-020 A word pushed into an empty FIFO at edge N SHALL appear on out_valid/out_data in the cycle following edge N (1-cycle latency).
REQ-021 Storage SHALL be DEPTH entries indexed by write and read pointers starting at 0, each wrapping from DEPTH-1 to 0.
REQ-022 Words SHALL be delivered in strict push order with no loss or duplication.
REQ-023 Push and pop in the same cycle SHALL both occur and leave count unchanged; push only increments count; pop only decrements count.
REQ-024 When full, in_valid SHALL be ignored even if a pop occurs the same cycle; the push is accepted the following cycle.
REQ-025 When empty, out_ready SHALL have no effect; out_data SHALL be don't-care.
REQ-026 almost_full SHALL equal (count >= AFULL_LVL); almost_empty SHALL equal (count <= AEMPTY_LVL); both combinational from count.
REQ-027 flush SHALL zero count and both pointers at the next edge; any push or pop in that cycle SHALL be dropped; flush has priority over push and pop.
REQ-028 Popped entries need not be cleared; storage contents SHALL NOT be observable except through out_data while out_valid is high.

Reset
REQ-029 RST high at a rising edge SHALL set count, both pointers, max_level and stall_cnt to 0; RST has priority over flush, push and pop.
REQ-030 After reset: in_ready=1, out_valid=0, almost_empty=1, almost_full=0 (for AFULL_LVL>0); reset mid-stream SHALL discard all stored words.
REQ-031 Storage array SHALL NOT require reset.

Configuration
REQ-032 Macro STREAM_FIFO_STATS_EN defined: max_level SHALL hold the highest count reached since reset or flush, updated the edge count rises above it; stall_cnt SHALL increment by 1 each cycle in_valid && !in_ready, saturating at 16'hFFFF, cleared by reset only.
REQ-033 Macro undefined: max_level, stall_cnt and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, then push 0xA5A5_0001 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5_0001, count=1.
REQ-035 DEPTH=32: push 32 words 0..31 with out_ready=0 -> in_ready=0, count=32, almost_full=1; then out_ready=1 -> 0..31 in order, count returns to 0.
REQ-036 Fill to 32, hold in_valid=1 with data 99, out_ready=1 for 1 cycle -> pop of word 0, push of 99 rejected; 99 accepted next cycle, count=32.
REQ-037 count=5, push and pop together for 40 cycles (pointers wrap) -> count stays 5, output sequence matches input sequence exactly.
REQ-038 count=10, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, neither word transferred.
REQ-039 STATS_EN, DEPTH=4: fill to 4, hold in_valid=1 for 3 stalled cycles -> max_level=4, stall_cnt=3; RST -> both 0.
